// File: rtl/calculation_mulit.sv
// Three-stage pipelined unsigned multiplier built from four 4-bit-slice partial products.
// Accepts a new operand pair every cycle; the product appears three rising edges later.
module calculation_mulit #(
   parameter int DATA_W = 16
) (
   input  logic                  mulit_clk,
   input  logic                  mulit_rst,
   input  logic [DATA_W-1:0]     mul_a,
   input  logic [DATA_W-1:0]     mul_b,
   output logic [2*DATA_W-1:0]   mul_out
);

   localparam int NIB   = 4;
   localparam int N_PP  = 4;
   localparam int PP_W  = DATA_W + NIB;
   localparam int S_W   = DATA_W + 2*NIB;
   localparam int OUT_W = 2*DATA_W;

   logic [PP_W-1:0]  pp_next [N_PP];
   logic [PP_W-1:0]  pp_reg  [N_PP];
   logic [S_W-1:0]   s0_next, s1_next;
   logic [S_W-1:0]   s0_reg,  s1_reg;
   logic [OUT_W-1:0] out_next;
   logic [OUT_W-1:0] out_reg;

   // Stage 1: one partial product per 4-bit slice of mul_b.
   genvar gi;
   generate
      for (gi = 0; gi < N_PP; gi++) begin : g_pp
         assign pp_next[gi] = PP_W'(mul_a) * PP_W'(mul_b[NIB*gi +: NIB]);

         always_ff @(posedge mulit_clk or negedge mulit_rst) begin
            if (!mulit_rst)
               pp_reg[gi] <= '0;
            else
               pp_reg[gi] <= pp_next[gi];
         end
      end
   endgenerate

   // Stage 2: pairwise merge of adjacent slices.
   always_comb begin
      s0_next = S_W'(pp_reg[0]) + (S_W'(pp_reg[1]) << NIB);
      s1_next = S_W'(pp_reg[2]) + (S_W'(pp_reg[3]) << NIB);
   end

   always_ff @(posedge mulit_clk or negedge mulit_rst) begin
      if (!mulit_rst) begin
         s0_reg <= '0;
         s1_reg <= '0;
      end else begin
         s0_reg <= s0_next;
         s1_reg <= s1_next;
      end
   end

   // Stage 3: final merge; the upper pair sits two slices (8 bits) higher.
   always_comb begin
      out_next = OUT_W'(s0_reg) + (OUT_W'(s1_reg) << (2*NIB));
   end

   always_ff @(posedge mulit_clk or negedge mulit_rst) begin
      if (!mulit_rst)
         out_reg <= '0;
      else
         out_reg <= out_next;
   end

   assign mul_out = out_reg;

endmodule

// File: tb/tb_calculation_mulit.sv
// Directed and random checks of the 3-stage multiplier: reset, hold, corners,
// streaming, mid-stream asynchronous reset and a long random stream.
module tb_calculation_mulit;

   logic        mulit_clk;
   logic        mulit_rst;
   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic [31:0] mul_out;

   int total_cnt;
   int bad_cnt;

   calculation_mulit #(.DATA_W(16)) dut (
      .mulit_clk (mulit_clk),
      .mulit_rst (mulit_rst),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_out   (mul_out)
   );

   initial mulit_clk = 1'b0;
   always #5 mulit_clk = ~mulit_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
      end
   endtask

   // Drive operands, let one rising edge sample them, then settle 1 time unit past the edge.
   task automatic tick(input logic [15:0] a, input logic [15:0] b);
      mul_a = a;
      mul_b = b;
      @(posedge mulit_clk);
      #1;
   endtask

   logic [15:0] sa [8];
   logic [15:0] sb [8];
   logic [31:0] se [8];
   logic [31:0] hist [3];

   initial begin
      total_cnt = 0;
      bad_cnt   = 0;

      // Reset held with operands present and clock running.
      mulit_rst = 1'b0;
      mul_a = 16'd510;
      mul_b = 16'd14;
      #2;
      check_val("rst_t0", mul_out, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick(16'd510, 16'd14);
         check_val("rst_hold", mul_out, 32'd0);
      end

      // Release mid-cycle; product must appear on the 3rd edge afterwards.
      mulit_rst = 1'b1;
      tick(16'd510, 16'd14);
      check_val("rel_e1", mul_out, 32'd0);
      tick(16'd510, 16'd14);
      check_val("rel_e2", mul_out, 32'd0);
      tick(16'd510, 16'd14);
      check_val("rel_e3", mul_out, 32'd7140);

      for (int i = 0; i < 7; i++) begin
         tick(16'd510, 16'd14);
         check_val("hold_510x14", mul_out, 32'd7140);
      end

      tick(16'd447, 16'd156);
      check_val("chg1_e1", mul_out, 32'd7140);
      tick(16'd447, 16'd156);
      check_val("chg1_e2", mul_out, 32'd7140);
      tick(16'd447, 16'd156);
      check_val("chg1_e3", mul_out, 32'h0001_1064);
      for (int i = 0; i < 3; i++) begin
         tick(16'd447, 16'd156);
         check_val("hold_447x156", mul_out, 32'd69732);
      end

      tick(16'd120, 16'd65);
      check_val("chg2_e1", mul_out, 32'd69732);
      tick(16'd120, 16'd65);
      check_val("chg2_e2", mul_out, 32'd69732);
      tick(16'd120, 16'd65);
      check_val("chg2_e3", mul_out, 32'h0000_1E78);
      tick(16'd120, 16'd65);
      check_val("hold_120x65", mul_out, 32'd7800);

      // Corners then the streaming set, one new pair per cycle.
      sa[0] = 16'h0000; sb[0] = 16'hFFFF; se[0] = 32'h0000_0000;
      sa[1] = 16'h0001; sb[1] = 16'hFFFF; se[1] = 32'h0000_FFFF;
      sa[2] = 16'hFFFF; sb[2] = 16'hFFFF; se[2] = 32'hFFFE_0001;
      sa[3] = 16'h8000; sb[3] = 16'h0002; se[3] = 32'h0001_0000;
      sa[4] = 16'd3;    sb[4] = 16'd5;    se[4] = 32'd15;
      sa[5] = 16'd100;  sb[5] = 16'd200;  se[5] = 32'd20000;
      sa[6] = 16'hFFFF; sb[6] = 16'h0001; se[6] = 32'h0000_FFFF;
      sa[7] = 16'h1234; sb[7] = 16'h5678; se[7] = 32'h0626_0060;
      for (int i = 0; i < 10; i++) begin
         int k;
         k = (i < 8) ? i : 7;
         tick(sa[k], sb[k]);
         if (i >= 2)
            check_val($sformatf("stream%0d", i - 2), mul_out, se[i - 2]);
      end

      // Mid-stream reset with three products in flight.
      tick(16'd7, 16'd9);
      tick(16'd11, 16'd13);
      tick(16'd17, 16'd19);
      check_val("pre_rst", mul_out, 32'd63);
      mul_a = 16'd21;
      mul_b = 16'd23;
      mulit_rst = 1'b0;
      #2;
      check_val("async_rst", mul_out, 32'd0);
      mulit_rst = 1'b1;
      tick(16'd21, 16'd23);
      check_val("post_rst_e1", mul_out, 32'd0);
      tick(16'd21, 16'd23);
      check_val("post_rst_e2", mul_out, 32'd0);
      tick(16'd21, 16'd23);
      check_val("post_rst_e3", mul_out, 32'd483);

      // Random stream against a 3-deep history of golden products.
      for (int i = 0; i < 10000; i++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         tick(ra, rb);
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = 32'(ra) * 32'(rb);
         if (i >= 2)
            check_val("rand", mul_out, hist[2]);
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
